pool_max2x2_stream: RTL and testbench

- Downstream consumer of the pooling stride-2 pair-select counter.
- Takes a raster-order pixel stream qualified by `start` and performs 2x2, stride-2 max pooling.
- Keeps one row of horizontal pair maxima in an internal line buffer and emits one pooled value per 2x2 window.
- Output feeds the next layer's input buffer.

---
 rtl/pool_max2x2_stream_if.sv | 30 +++
 rtl/pool_max2x2_stream.sv | 123 ++++++++++++
 tb/tb_pool_max2x2_stream.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pool_max2x2_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : pool_max2x2_stream_if
// Description : Pixel-in / pooled-value-out stream bundle for the 2x2 max
//               pooling block. The master side drives pixels; the slave side
//               is the pooling engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface pool_max2x2_stream_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              clr;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              busy;

  modport master (
    output start, clr, data_in,
    input  out_valid, data_out, frame_done, busy
  );

  modport slave (
    input  start, clr, data_in,
    output out_valid, data_out, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/pool_max2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : pool_max2x2_stream
// Description : 2x2 stride-2 signed max pooling over a raster-order pixel
//               stream. Horizontal pair maxima of even rows are parked in a
//               half-row line buffer; odd rows combine with them to emit one
//               pooled value per window, one cycle after the closing pixel.
//               Optional macro POOL_RELU_EN clamps negative results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_max2x2_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pool_max2x2_stream_if.slave  bus
);

  localparam int c_col_w    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int c_row_w    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int c_lb_depth = IMG_W / 2;
  localparam int c_lb_aw    = (c_lb_depth > 1) ? $clog2(c_lb_depth) : 1;
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);

  logic [c_col_w-1:0]        r_col;
  logic [c_row_w-1:0]        r_row;
  logic signed [DATA_W-1:0]  r_h;
  logic signed [DATA_W-1:0]  r_lbuf [c_lb_depth];
  logic                      r_out_valid;
  logic [DATA_W-1:0]         r_data_out;
  logic                      r_frame_done;

  logic                      w_accept;
  logic                      w_phase;
  logic                      w_row_odd;
  logic                      w_col_last;
  logic                      w_row_last;
  logic [c_lb_aw-1:0]        w_lb_idx;
  logic signed [DATA_W-1:0]  w_din;
  logic signed [DATA_W-1:0]  w_hmax;
  logic signed [DATA_W-1:0]  w_lb_rd;
  logic signed [DATA_W-1:0]  w_pool;
  logic [DATA_W-1:0]         w_out_val;
  logic                      w_emit;
  logic                      w_lb_wr;

  // clr overrides start, so a pixel presented with clr is simply dropped
  assign w_accept   = bus.start & ~bus.clr;
  assign w_phase    = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_col_last = (r_col == c_col_last);
  assign w_row_last = (r_row == c_row_last);
  assign w_lb_idx   = c_lb_aw'(r_col >> 1);
  assign w_din      = bus.data_in;

  assign w_hmax  = (w_din > r_h) ? w_din : r_h;
  assign w_lb_rd = r_lbuf[w_lb_idx];
  assign w_pool  = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;

`ifdef POOL_RELU_EN
  assign w_out_val = w_pool[DATA_W-1] ? '0 : w_pool;
`else
  assign w_out_val = w_pool;
`endif

  assign w_emit  = w_accept & w_phase & w_row_odd;
  assign w_lb_wr = w_accept & w_phase & ~w_row_odd;

  // Raster position counters and the even-column hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_h   <= '0;
    end else if (bus.clr) begin
      r_col <= '0;
      r_row <= '0;
      r_h   <= '0;
    end else if (bus.start) begin
      if (!w_phase) begin
        r_h <= w_din;
      end
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Even rows park their pair maxima; row 0 always fills before row 1 reads
  always_ff @(posedge clk) begin
    if (w_lb_wr) begin
      r_lbuf[w_lb_idx] <= w_hmax;
    end
  end

  // Output register: one-cycle pulse, data held between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_data_out   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= w_emit & w_col_last & w_row_last;
      if (w_emit) begin
        r_data_out <= w_out_val;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.data_out   = r_data_out;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_col != '0) | (r_row != '0);

endmodule
`default_nettype wire

// File: tb/tb_pool_max2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_max2x2_stream
// Description : Directed and randomized bench for pool_max2x2_stream on a
//               4x4 image; expected windows come from a frame-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_max2x2_stream;

  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pool_max2x2_stream_if #(.DATA_W(DW)) bus ();

  pool_max2x2_stream #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          pos;
  int          frame_pix [NPIX];
  logic [DW-1:0] last_out;
  int          obs_q [$];
  int          e_asc [4];
  int          e_neg [4];
  int          e_m1  [4];
  int          arr   [NPIX];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int smax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Max over the 2x2 window whose bottom-right pixel is (r, c)
  function automatic int window_max(input int r, input int c);
    int m;
    m = smax(smax(frame_pix[(r-1)*IW + c-1], frame_pix[(r-1)*IW + c]),
             smax(frame_pix[r*IW + c-1],     frame_pix[r*IW + c]));
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // One clock cycle of stimulus followed by checks of every output
  task automatic step(input bit s, input int d, input bit c);
    int  r, col, exp_d;
    bit  exp_v, exp_fd;
    @(negedge clk);
    bus.start   = s;
    bus.data_in = d[DW-1:0];
    bus.clr     = c;
    @(posedge clk);
    #1;
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    exp_d  = 0;
    if (c) begin
      pos = 0;
    end else if (s) begin
      r   = pos / IW;
      col = pos % IW;
      frame_pix[pos] = d;
      if ((r % 2 == 1) && (col % 2 == 1)) begin
        exp_v  = 1'b1;
        exp_d  = window_max(r, col);
        exp_fd = (pos == NPIX - 1);
      end
      pos = (pos + 1) % NPIX;
    end
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
    check("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
    if (exp_v) begin
      last_out = exp_d[DW-1:0];
      obs_q.push_back(int'($signed(bus.data_out)));
    end
    check("data_out", {16'd0, bus.data_out}, {16'd0, last_out});
    check("busy", {31'd0, bus.busy}, {31'd0, (pos != 0)});
  endtask

  task automatic check_q(input string tag, input int e [4]);
    check({tag, "_count"}, obs_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) begin
        check(tag, obs_q[i], e[i]);
      end
    end
    obs_q.delete();
  endtask

  task automatic feed_asc();
    for (int i = 0; i < NPIX; i++) step(1'b1, i, 1'b0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.clr     = 1'b0;
    bus.data_in = '0;
    pos      = 0;
    last_out = '0;
    e_asc = '{5, 7, 13, 15};
    e_neg = '{-11, -9, -3, -1};
    for (int i = 0; i < 4; i++) begin
      e_neg[i] = relu(e_neg[i]);
      e_m1[i]  = relu(-1);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data_out", {16'd0, bus.data_out}, 32'd0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending frame, start held high
    feed_asc();
    step(1'b0, 0, 1'b0);
    check_q("asc", e_asc);

    // All -8 with a single -1 somewhere in each window
    for (int i = 0; i < NPIX; i++) arr[i] = -8;
    for (int wr = 0; wr < 2; wr++) begin
      for (int wc = 0; wc < 2; wc++) begin
        int k;
        k = int'($urandom_range(0, 3));
        arr[(2*wr + k/2)*IW + 2*wc + k%2] = -1;
      end
    end
    for (int i = 0; i < NPIX; i++) step(1'b1, arr[i], 1'b0);
    check_q("signed", e_m1);

    // Two back-to-back random frames; the model checks every cycle
    for (int i = 0; i < 2*NPIX; i++) begin
      step(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0);
    end
    obs_q.delete();

    // Ascending with alternate-cycle start and a 5-cycle gap at row end
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, i, 1'b0);
      step(1'b0, int'($urandom_range(0, 65535)), 1'b0);
      if (i % IW == IW - 1) begin
        repeat (5) step(1'b0, int'($urandom_range(0, 65535)), 1'b0);
      end
    end
    check_q("gaps", e_asc);

    // Partial frame aborted by clr coinciding with a 7th pixel
    for (int i = 0; i < 6; i++) step(1'b1, 100 + i, 1'b0);
    step(1'b1, 200, 1'b1);
    obs_q.delete();
    feed_asc();
    check_q("clr", e_asc);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 10; i++) step(1'b1, 50 + i, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_data_out", {16'd0, bus.data_out}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    pos      = 0;
    last_out = '0;
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    feed_asc();
    check_q("post_rst", e_asc);

    // Negative frame -16..-1
    for (int i = 0; i < NPIX; i++) step(1'b1, i - 16, 1'b0);
    step(1'b0, 0, 1'b0);
    check_q("neg", e_neg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
